seq_divider: RTL and testbench

//  Sequential restoring divider: the inverse-direction unit of the team's 16x16->32 start/done multiplier datapath.

---
 rtl/seq_divider.sv | 137 +++++++++++++
 tb/tb_seq_divider.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, one quotient bit per clock
//
// Purpose: unsigned DIVIDEND_W / DIVISOR_W division with a start/done handshake.
//   start is accepted only in IDLE. The divider then spends DIVIDEND_W cycles in BUSY
//   and one cycle in DONE, where done pulses and the registered results are valid.
//   quotient and remainder hold their values until the next DONE load.
// Optional feature macro: SEQ_DIV_DBZ_EN
//   Adds o_div_by_zero. A zero divisor skips BUSY and goes straight to DONE with
//   quotient = all ones and remainder = 0.
//   Without the macro, a zero divisor runs the normal iteration. That gives
//   quotient = all ones and remainder = dividend[DIVISOR_W-1:0].
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_start        operation request, sampled in IDLE only
//   i_dividend     unsigned dividend, latched on accept
//   i_divisor      unsigned divisor, latched on accept
//   o_quotient     registered quotient
//   o_remainder    registered remainder
//   o_busy         high while iterating
//   o_done         one-cycle result-valid pulse
//   o_div_by_zero  (SEQ_DIV_DBZ_EN only) set on a zero-divisor done, held until next done
module seq_divider #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic [DIVIDEND_W-1:0] o_quotient,
    output logic [DIVISOR_W-1:0]  o_remainder,
    output logic                  o_busy,
    output logic                  o_done
`ifdef SEQ_DIV_DBZ_EN
    ,
    output logic                  o_div_by_zero
`endif
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [DIVIDEND_W-1:0] r_q;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_quot_out;
    logic [DIVISOR_W-1:0]  r_rem_out;
`ifdef SEQ_DIV_DBZ_EN
    logic                  r_dbz;
`endif

    logic [DIVISOR_W:0]    w_shift;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_sub;
    logic [DIVISOR_W-1:0]  w_rem_next;
    logic [DIVIDEND_W-1:0] w_q_next;

    // The shifted partial remainder needs one extra bit for the compare.
    // When the compare succeeds, the difference is below the divisor.
    // The subtraction can therefore be done at DIVISOR_W bits without losing anything.
    // With a zero divisor the top bit is simply dropped on the next shift.
    // That dropping is what leaves dividend[DIVISOR_W-1:0] as the remainder.
    assign w_shift    = {r_rem, r_q[DIVIDEND_W-1]};
    assign w_ge       = (w_shift >= {1'b0, r_divisor});
    assign w_sub      = w_shift[DIVISOR_W-1:0] - r_divisor;
    assign w_rem_next = w_ge ? w_sub : w_shift[DIVISOR_W-1:0];
    assign w_q_next   = {r_q[DIVIDEND_W-2:0], w_ge};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_q        <= '0;
            r_rem      <= '0;
            r_divisor  <= '0;
            r_cnt      <= '0;
            r_quot_out <= '0;
            r_rem_out  <= '0;
`ifdef SEQ_DIV_DBZ_EN
            r_dbz      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
`ifdef SEQ_DIV_DBZ_EN
                        if (i_divisor == '0) begin
                            r_state    <= S_DONE;
                            r_quot_out <= '1;
                            r_rem_out  <= '0;
                            r_dbz      <= 1'b1;
                        end else
`endif
                        begin
                            r_state   <= S_BUSY;
                            r_q       <= i_dividend;
                            r_rem     <= '0;
                            r_divisor <= i_divisor;
                            r_cnt     <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    r_q   <= w_q_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state    <= S_DONE;
                        r_quot_out <= w_q_next;
                        r_rem_out  <= w_rem_next;
`ifdef SEQ_DIV_DBZ_EN
                        r_dbz      <= 1'b0;
`endif
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_quotient  = r_quot_out;
    assign o_remainder = r_rem_out;
    assign o_busy      = (r_state == S_BUSY);
    assign o_done      = (r_state == S_DONE);
`ifdef SEQ_DIV_DBZ_EN
    assign o_div_by_zero = r_dbz;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic [31:0] quot;
    logic [15:0] rem;
    logic        busy;
    logic        done;
    logic        dbz_got;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_divider #(.DIVIDEND_W(32), .DIVISOR_W(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_dividend  (dividend),
        .i_divisor   (divisor),
        .o_quotient  (quot),
        .o_remainder (rem),
        .o_busy      (busy),
        .o_done      (done)
`ifdef SEQ_DIV_DBZ_EN
        ,
        .o_div_by_zero (dbz_got)
`endif
    );

`ifndef SEQ_DIV_DBZ_EN
    assign dbz_got = 1'b0;
`endif

    // Reference model: an accepted operation is represented only by its arithmetic
    // result and the number of busy cycles still to run.
    logic [31:0] m_q = '0, p_q = '0;
    logic [15:0] m_r = '0, p_r = '0;
    logic        m_done = 1'b0;
    logic        m_dbz = 1'b0;
    int          m_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_q = '0; m_r = '0; m_done = 1'b0; m_dbz = 1'b0; m_left = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1'b1; m_q = p_q; m_r = p_r; m_dbz = 1'b0;
            end
        end else if (start) begin
            if (divisor == 16'd0) begin
`ifdef SEQ_DIV_DBZ_EN
                m_done = 1'b1; m_q = '1; m_r = '0; m_dbz = 1'b1;
`else
                p_q = 32'hFFFF_FFFF; p_r = dividend[15:0]; m_left = 32;
`endif
            end else begin
                p_q = dividend / {16'd0, divisor};
                p_r = 16'(dividend % {16'd0, divisor});
                m_left = 32;
            end
        end
    end

    always @(negedge clk) begin
        n_tests++;
        if (busy !== (m_left > 0) || done !== m_done || quot !== m_q ||
            rem !== m_r || dbz_got !== m_dbz) begin
            n_fail++;
            $display("FAIL cycle_check t=%0t got busy=%b done=%b q=%h r=%h dbz=%b exp busy=%b done=%b q=%h r=%h dbz=%b",
                     $time, busy, done, quot, rem, dbz_got, (m_left > 0), m_done, m_q, m_r, m_dbz);
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100; n++) begin
            if (!busy && !done) return;
            @(posedge clk); #1;
        end
        chk("wait_idle_timeout", 64'd1, 64'd0);
    endtask

    // lat counts cycles after the accept edge; 1 = the cycle right after it.
    task automatic run_op(input logic [31:0] dd, input logic [15:0] dv,
                          output logic [31:0] q, output logic [15:0] r,
                          output int lat, output int bcnt);
        wait_idle();
        dividend = dd; divisor = dv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0;
        for (int n = 1; n <= 100; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
            if (done) begin lat = n; break; end
            if (busy) bcnt++;
        end
        if (lat == 0) chk("run_op_done_timeout", 64'd1, 64'd0);
        q = quot; r = rem;
    endtask

    logic [31:0] q, rdd;
    logic [15:0] r, rdv;
    int          lat, bcnt, dcount;
    time         t_done[3];
    logic [31:0] h_dd[3] = '{32'd15, 32'd1000, 32'd0};
    logic [15:0] h_dv[3] = '{16'd10, 16'd1000, 16'd3};
    logic [31:0] h_q[3]  = '{32'd1, 32'd1, 32'd0};
    logic [15:0] h_r[3]  = '{16'd5, 16'd0, 16'd0};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_q", 64'(quot), 64'd0);
        chk("reset_r", 64'(rem), 64'd0);
        chk("reset_busy_done", 64'({busy, done, dbz_got}), 64'd0);
        rst = 1'b0;

        // Single op, latency and busy length.
        run_op(32'd100, 16'd7, q, r, lat, bcnt);
        chk("t1_q", 64'(q), 64'd14);
        chk("t1_r", 64'(r), 64'd2);
        chk("t1_lat", 64'(lat), 64'd33);
        chk("t1_busy_cycles", 64'(bcnt), 64'd32);

        // Reset in mid-operation.
        wait_idle();
        dividend = 32'd100; divisor = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t4_rst_q", 64'(quot), 64'd0);
        chk("t4_rst_r", 64'(rem), 64'd0);
        chk("t4_rst_busy_done", 64'({busy, done}), 64'd0);
        dcount = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("t4_no_done_after_abort", 64'(dcount), 64'd0);
        run_op(32'd100, 16'd7, q, r, lat, bcnt);
        chk("t4_q", 64'(q), 64'd14);
        chk("t4_r", 64'(r), 64'd2);
        chk("t4_lat", 64'(lat), 64'd33);

        // Boundary operands.
        run_op(32'hFFFF_FFFF, 16'hFFFF, q, r, lat, bcnt);
        chk("t2_max_q", 64'(q), 64'h0001_0001);
        chk("t2_max_r", 64'(r), 64'd0);
        run_op(32'd5, 16'd9, q, r, lat, bcnt);
        chk("t2_small_q", 64'(q), 64'd0);
        chk("t2_small_r", 64'(r), 64'd5);

        // start held high across three back-to-back operations.
        wait_idle();
        dividend = h_dd[0]; divisor = h_dv[0]; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) @(posedge clk);
            else repeat (2) @(posedge clk);
            #1;
            repeat (5) @(posedge clk);
            #1;
            dividend = $urandom; divisor = 16'($urandom);
            lat = 0;
            for (int n = 0; n < 60; n++) begin
                if (done) begin lat = 1; break; end
                @(posedge clk); #1;
            end
            if (lat == 0) chk("t3_done_timeout", 64'd1, 64'd0);
            t_done[k] = $time;
            chk($sformatf("t3_q%0d", k), 64'(quot), 64'(h_q[k]));
            chk($sformatf("t3_r%0d", k), 64'(rem), 64'(h_r[k]));
            if (k < 2) begin
                dividend = h_dd[k+1]; divisor = h_dv[k+1];
            end else begin
                start = 1'b0;
            end
        end
        chk("t3_spacing01", 64'((t_done[1] - t_done[0]) / 10), 64'd34);
        chk("t3_spacing12", 64'((t_done[2] - t_done[1]) / 10), 64'd34);

        // Zero divisor.
        run_op(32'h1234_5678, 16'd0, q, r, lat, bcnt);
`ifdef SEQ_DIV_DBZ_EN
        chk("t5_dbz_lat", 64'(lat), 64'd1);
        chk("t5_dbz_q", 64'(q), 64'hFFFF_FFFF);
        chk("t5_dbz_r", 64'(r), 64'd0);
        chk("t5_dbz_flag", 64'(dbz_got), 64'd1);
`else
        chk("t5_lat", 64'(lat), 64'd33);
        chk("t5_q", 64'(q), 64'hFFFF_FFFF);
        chk("t5_r", 64'(r), 64'h5678);
`endif
        run_op(32'd100, 16'd7, q, r, lat, bcnt);
        chk("t5_after_q", 64'(q), 64'd14);
        chk("t5_after_flag", 64'(dbz_got), 64'd0);

        // Random operations with a nonzero divisor.
        for (int i = 0; i < 1000; i++) begin
            rdd = $urandom >> $urandom_range(0, 31);
            case ($urandom_range(0, 2))
                0:       rdv = 16'($urandom_range(1, 15));
                1:       rdv = 16'($urandom_range(1, 255));
                default: rdv = 16'($urandom_range(1, 65535));
            endcase
            run_op(rdd, rdv, q, r, lat, bcnt);
            chk("t6_identity", 64'(q) * 64'(rdv) + 64'(r), 64'(rdd));
            chk("t6_rem_lt_div", 64'(r < rdv), 64'd1);
            chk("t6_lat", 64'(lat), 64'd33);
        end

        wait_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

endmodule
